// File: rtl/mdu_iter_if.sv
// rtl/mdu_iter_if.sv - start/busy/done handshake and operand/result bundle for mdu_iter
interface mdu_iter_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] alu_in1;
    logic [XLEN-1:0] alu_in2;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, alu_in1, alu_in2,
        input  busy, done, result
    );

    modport slave (
        input  start, op, alu_in1, alu_in2,
        output busy, done, result
    );
endinterface

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
// Optional MDU_FAST_MUL_EN: single-cycle combinational multiply; divides stay iterative.
module mdu_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic       clk,
    input  logic       rst,
    mdu_iter_if.slave  mdu
);
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t state, state_nx;

    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic             q_neg;
    logic             r_neg;
    logic [XLEN-1:0]  opnd_q;
    logic [XLEN-1:0]  acc_hi;
    logic [XLEN-1:0]  acc_lo;
    logic [XLEN-1:0]  result_q;

    logic             is_div;
    logic             a_signed;
    logic             b_signed;
    logic             a_neg;
    logic             b_neg;
    logic [XLEN-1:0]  a_mag;
    logic [XLEN-1:0]  b_mag;
    logic             div_zero;
    logic             div_ovf;
    logic             special;
    logic [XLEN-1:0]  special_res;
    logic             fast_mul;
    logic [XLEN-1:0]  fast_res;
    logic             accept;
    logic             last_step;

    // Operand decode on the live inputs; only consumed on the accepting edge.
    always_comb begin
        is_div   = mdu.op[2];
        a_signed = (mdu.op == OP_MUL) || (mdu.op == OP_MULH) || (mdu.op == OP_MULHSU) ||
                   (mdu.op == OP_DIV) || (mdu.op == OP_REM);
        b_signed = (mdu.op == OP_MUL) || (mdu.op == OP_MULH) ||
                   (mdu.op == OP_DIV) || (mdu.op == OP_REM);
        a_neg    = a_signed && mdu.alu_in1[XLEN-1];
        b_neg    = b_signed && mdu.alu_in2[XLEN-1];
        a_mag    = a_neg ? -mdu.alu_in1 : mdu.alu_in1;
        b_mag    = b_neg ? -mdu.alu_in2 : mdu.alu_in2;
        div_zero = is_div && (mdu.alu_in2 == '0);
        div_ovf  = is_div && !mdu.op[0] && (mdu.alu_in1 == INT_MIN) && (mdu.alu_in2 == '1);
        special  = div_zero || div_ovf;
        if (div_zero) begin
            special_res = mdu.op[1] ? mdu.alu_in1 : '1;
        end else begin
            special_res = mdu.op[1] ? '0 : INT_MIN;
        end
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a;
    logic [2*XLEN-1:0] fast_b;
    logic [2*XLEN-1:0] fast_prod;

    always_comb begin
        fast_a    = {{XLEN{a_signed && mdu.alu_in1[XLEN-1]}}, mdu.alu_in1};
        fast_b    = {{XLEN{b_signed && mdu.alu_in2[XLEN-1]}}, mdu.alu_in2};
        fast_prod = fast_a * fast_b;
        fast_mul  = !is_div;
        fast_res  = (mdu.op == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`else
    always_comb begin
        fast_mul = 1'b0;
        fast_res = '0;
    end
`endif

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [XLEN-1:0]   hi_nx;
    logic [XLEN-1:0]   lo_nx;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   final_res;

    // One radix-2 step: multiply keeps {acc_hi, acc_lo} as product/multiplier shifting right,
    // divide keeps acc_hi as partial remainder and acc_lo as dividend/quotient shifting left.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (op_q[2]) begin
            if (div_diff[XLEN]) begin
                hi_nx = div_shift[XLEN-1:0];
                lo_nx = {acc_lo[XLEN-2:0], 1'b0};
            end else begin
                hi_nx = div_diff[XLEN-1:0];
                lo_nx = {acc_lo[XLEN-2:0], 1'b1};
            end
        end else begin
            hi_nx = mul_sum[XLEN:1];
            lo_nx = {mul_sum[0], acc_lo[XLEN-1:1]};
        end

        prod   = {hi_nx, lo_nx};
        prod_s = q_neg ? -prod : prod;
        quo_s  = q_neg ? -lo_nx : lo_nx;
        rem_s  = r_neg ? -hi_nx : hi_nx;
        case (op_q)
            OP_MUL:                      final_res = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             final_res = quo_s;
            default:                     final_res = rem_s;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        last_step = (cnt == CNT_W'(XLEN - 1));
        mdu.busy  = 1'b0;
        mdu.done  = 1'b0;
        case (state)
            S_IDLE, S_FIN: begin
                mdu.done = (state == S_FIN);
                if (mdu.start) begin
                    accept   = 1'b1;
                    state_nx = (special || fast_mul) ? S_FIN : S_RUN;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_RUN: begin
                mdu.busy = 1'b1;
                if (last_step) begin
                    state_nx = S_FIN;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            op_q     <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            opnd_q   <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            result_q <= '0;
        end else if (accept) begin
            cnt    <= '0;
            op_q   <= mdu.op;
            q_neg  <= a_neg ^ b_neg;
            r_neg  <= a_neg;
            opnd_q <= is_div ? b_mag : a_mag;
            acc_hi <= '0;
            acc_lo <= is_div ? a_mag : b_mag;
            if (special) begin
                result_q <= special_res;
            end else if (fast_mul) begin
                result_q <= fast_res;
            end
        end else if (state == S_RUN) begin
            cnt    <= cnt + CNT_W'(1);
            acc_hi <= hi_nx;
            acc_lo <= lo_nx;
            if (last_step) begin
                result_q <= final_res;
            end
        end
    end

    assign mdu.result = result_q;
endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - self-checking bench for mdu_iter with a behavioural reference model
module tb_mdu_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mdu_iter_if #(.XLEN(32)) bus ();

    mdu_iter #(.XLEN(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .mdu (bus)
    );

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] ub;
        logic [63:0]        p;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return MUL_LAT;
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Reference timeline: cycles remaining until done (1 = done cycle, >1 = busy).
    int          rem_cyc = 0;
    logic [31:0] pend    = '0;
    logic [31:0] exp_res = '0;
    bit          started = 0;

    always @(posedge clk) begin
        started = 1;
        if (rst) begin
            rem_cyc = 0;
            exp_res = '0;
        end else begin
            if (rem_cyc > 1) begin
                rem_cyc--;
            end else if (bus.start) begin
                rem_cyc = model_lat(bus.op, bus.alu_in1, bus.alu_in2);
                pend    = model(bus.op, bus.alu_in1, bus.alu_in2);
            end else begin
                rem_cyc = 0;
            end
            if (rem_cyc == 1) exp_res = pend;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("cyc_busy",   {31'b0, bus.busy}, 32'(rem_cyc > 1));
            check("cyc_done",   {31'b0, bus.done}, 32'(rem_cyc == 1));
            check("cyc_result", bus.result, exp_res);
        end
    end

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expv, input int lat);
        int cyc;
        int busy_cnt;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = o;
        bus.alu_in1 = a;
        bus.alu_in2 = b;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.op      = 3'($urandom);
        bus.alu_in1 = $urandom;
        bus.alu_in2 = $urandom;
        cyc      = 1;
        busy_cnt = 0;
        while (!bus.done && cyc < 40) begin
            busy_cnt += int'(bus.busy);
            @(negedge clk);
            cyc++;
        end
        check({name, "_lat"},  32'(cyc), 32'(lat));
        check({name, "_busy"}, 32'(busy_cnt), 32'(lat - 1));
        check({name, "_res"},  bus.result, expv);
    endtask

    initial begin
        int          cyc;
        bit          done_seen;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        bus.start   = 1'b0;
        bus.op      = '0;
        bus.alu_in1 = '0;
        bus.alu_in2 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_busy",   {31'b0, bus.busy}, 32'h0);
        check("reset_done",   {31'b0, bus.done}, 32'h0);
        check("reset_result", bus.result, 32'h0);

        check("model_mul",  model(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        check("model_mulh", model(3'd1, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
        check("model_hsu",  model(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        check("model_rem",  model(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

        run_op("mul",     3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("mulh",    3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run_op("mulhu",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mulhsu",  3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        run_op("div",     3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
        run_op("rem",     3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
        run_op("divu",    3'd5, 32'd100,        32'd7,         32'd14,        33);
        run_op("remu",    3'd7, 32'd100,        32'd7,         32'd2,         33);
        run_op("div0",    3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem0",    3'd6, 32'd5,          32'd0,         32'd5,         1);
        run_op("divu0",   3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        run_op("remu0",   3'd7, 32'd9,          32'd0,         32'd9,         1);
        run_op("div_ovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1);
        run_op("mul_neg", 3'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h1,         MUL_LAT);
        run_op("rem_sgn", 3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         33);

        for (int i = 0; i < 10; i++) begin
            ro = 3'($urandom);
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : $urandom >> (i % 4) * 8;
            run_op("rand", ro, ra, rb, model(ro, ra, rb), model_lat(ro, ra, rb));
        end

        // start pulse while busy must be ignored
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd5; bus.alu_in1 = 32'd100; bus.alu_in2 = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 40) begin
            if (cyc == 5) begin
                bus.start = 1'b1; bus.op = 3'd7; bus.alu_in1 = 32'd55; bus.alu_in2 = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        check("ignore_lat", 32'(cyc), 32'd33);
        check("ignore_res", bus.result, 32'd14);

        // back-to-back start in the done cycle
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd5; bus.alu_in1 = 32'd100; bus.alu_in2 = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_first_lat", 32'(cyc), 32'd33);
        bus.start = 1'b1; bus.op = 3'd5; bus.alu_in1 = 32'd200; bus.alu_in2 = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_second_lat", 32'(cyc), 32'd33);
        check("b2b_second_res", bus.result, 32'd28);

        // reset in the middle of an operation
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd4; bus.alu_in1 = 32'd1000; bus.alu_in2 = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy",   {31'b0, bus.busy}, 32'h0);
        check("midrst_done",   {31'b0, bus.done}, 32'h0);
        check("midrst_result", bus.result, 32'h0);
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) done_seen = 1;
        end
        check("midrst_no_done", {31'b0, done_seen}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative RV32M multiply/divide unit, sitting beside the ALU downstream of the alu2_mux operand stage.
- Consumes the same operands as the ALU: alu_in1 comes from the alu1 mux and alu_in2 from the alu2 mux (always rs2_d for M-extension ops).
- Produces a 32-bit result after a multi-cycle computation.
- Exposes a start/busy/done handshake so the core control can stall the pipeline while it runs.

Parameters:
- XLEN, 32, operand/result width; must equal `REG_LEN.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only while busy=0.
- op  input  3  instruction funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- alu_in1  input  XLEN  operand A (rs1_d).
- alu_in2  input  XLEN  operand B (rs2_d, from the alu2 mux).
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when result is valid.
- result  output  XLEN  registered result; held until the next accepted start.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - FSM goes to IDLE; busy=0, done=0, result=0, internal registers cleared.
  - Applies at any point, including mid-operation; any in-flight operation is discarded with no done pulse.
- FSM states: IDLE, RUN, FIN.
  - IDLE: start=1 latches op, alu_in1, alu_in2 → RUN; counter=0; busy=1 from the next cycle.
  - RUN: one radix-2 step per cycle, XLEN steps. When counter==XLEN-1 → FIN.
  - FIN: result written; done=1 and busy=0 for exactly this cycle. A start in FIN is accepted like IDLE (back-to-back ops); otherwise → IDLE.
- Latency: start sampled at edge k ⇒ busy high cycles k+1..k+XLEN, done high at cycle k+XLEN+1 (33 cycles for XLEN=32).
- start while busy=1 is ignored: no queueing, no effect on the running op. Inputs may change freely after the accepting edge.
- Multiply (shift-add on magnitudes):
  - Operand signedness: MUL/MULH signed×signed; MULHSU signed A × unsigned B; MULHU unsigned×unsigned.
  - Full 2·XLEN product; 2's-complement negate at FIN if the operand signs differ (signed operands only).
  - MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2·XLEN-1:XLEN].
- Divide (restoring, on magnitudes):
  - Quotient is negated if signed and the operand signs differ.
  - Remainder takes the sign of the dividend (signed ops).
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases, resolved at the accepting edge (IDLE→FIN directly, done at k+1, busy never asserted):
  - Divide by zero (alu_in2==0): DIV/DIVU → all-ones; REM/REMU → alu_in1.
  - Signed overflow (DIV/REM, alu_in1=0x80000000, alu_in2=0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- result changes only in FIN (or at reset); it is stable in IDLE and RUN.
- All arithmetic is modulo 2^XLEN; internal accumulators are XLEN+1 bits for the divide subtraction and 2·XLEN bits for the product.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined: MUL/MULH/MULHSU/MULHU use a single-cycle combinational product on sign-extended XLEN+1-bit operands. Start at edge k → FIN, done at k+1, busy never asserted. Divide ops are unchanged.
- Undefined: all multiplies use the iterative path with XLEN+1 cycle latency. No combinational multiplier is inferred.

Test Plan:
- MUL alu_in1=7, alu_in2=0xFFFFFFFD → result=0xFFFFFFEB; done exactly 33 cycles after start, busy high for 32 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF, REM 5/0 → 5, DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM same → 0; each with done at k+1 and busy never high.
- Start DIVU, pulse start with new operands at cycle 5 → ignored, original result returned. Assert rst at cycle 10 of a new op → busy=0, done=0, result=0 the next cycle, no later done.
- With MDU_FAST_MUL_EN: MUL 7×0xFFFFFFFD → 0xFFFFFFEB with done at k+1. Back-to-back start in the FIN cycle of a DIVU → second op accepted, its done arrives 33 cycles later.
